// File: rtl/ahb2_arbiter_nm_if.sv
// Purpose: request/grant and ownership bundle between AHB2 masters, bus fabric and the N-master arbiter.
// Latency: none (wires only).
// Backpressure: hready_i carries the bus-level stall into the arbiter.
// Ports: hbusreq_i/hlock_i per master, htrans_i/hburst_i of the address-phase owner, hready_i,
//        hgrant_o one-hot grant, hmaster_o/hmaster_data_o owner indices, hmastlock_o.
interface ahb2_arbiter_nm_if #(
    parameter int NUM_MST = 4
);
    localparam int MW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

    logic [NUM_MST-1:0] hbusreq_i;
    logic [NUM_MST-1:0] hlock_i;
    logic [1:0]         htrans_i;
    logic [2:0]         hburst_i;
    logic               hready_i;
    logic [NUM_MST-1:0] hgrant_o;
    logic [MW-1:0]      hmaster_o;
    logic [MW-1:0]      hmaster_data_o;
    logic               hmastlock_o;

    // Requesting side: masters and fabric drive requests and the owner's transfer type.
    modport master (
        output hbusreq_i,
        output hlock_i,
        output htrans_i,
        output hburst_i,
        output hready_i,
        input  hgrant_o,
        input  hmaster_o,
        input  hmaster_data_o,
        input  hmastlock_o
    );

    // Arbiter side.
    modport slave (
        input  hbusreq_i,
        input  hlock_i,
        input  htrans_i,
        input  hburst_i,
        input  hready_i,
        output hgrant_o,
        output hmaster_o,
        output hmaster_data_o,
        output hmastlock_o
    );
endinterface

// File: rtl/ahb2_arbiter_nm.sv
// Purpose: N-master AHB2 arbiter, fixed-priority or round-robin, burst- and HLOCK-aware.
// Latency: grant registers on the arbitration edge; ownership one hready edge later, data phase one more.
// Backpressure: hready_i low freezes grant, owner indices, lock flag and burst counter.
// Ports: clk, rst_n (async, active-low), bus (slave modport): hbusreq_i, hlock_i, htrans_i, hburst_i,
//        hready_i in; hgrant_o (one-hot), hmaster_o, hmaster_data_o, hmastlock_o out.
module ahb2_arbiter_nm #(
    parameter int NUM_MST     = 4,
    parameter int DEFAULT_MST = 0,
    parameter int ARB_MODE    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    ahb2_arbiter_nm_if.slave  bus
);
    localparam int MW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MST);
    localparam logic [MW:0]   NUM_W   = (MW+1)'(NUM_MST);
    localparam logic [MW:0]   ONE_W   = (MW+1)'(1);

    typedef enum logic [1:0] {
        TR_IDLE   = 2'd0,
        TR_BUSY   = 2'd1,
        TR_NONSEQ = 2'd2,
        TR_SEQ    = 2'd3
    } htrans_e;

    // Beats still to issue after the NONSEQ address; WRAPn and INCRn share a length.
    function automatic logic [3:0] beats_after_first(input logic [2:0] hburst);
        logic [3:0] r;
        case (hburst)
            3'd2, 3'd3: r = 4'd3;
            3'd4, 3'd5: r = 4'd7;
            3'd6, 3'd7: r = 4'd15;
            default:    r = 4'd0;   // SINGLE, INCR
        endcase
        return r;
    endfunction

    logic [MW-1:0]          grant_idx;
    logic [MW-1:0]          hmaster_q;
    logic [MW-1:0]          hmaster_data_q;
    logic                   hmastlock_q;
    logic [3:0]             cnt;
    logic [3:0]             cnt_nxt;
    logic [MW-1:0]          winner;
    logic                   arb_ok;
    logic                   owner_lock;
    logic [MW:0]            grant_p1;
    logic [MW:0]            cand;
    logic [2*NUM_MST-1:0]   req_dbl;
    logic [2*NUM_MST-1:0]   req_rot;
    logic [NUM_MST-1:0]     grant_vec;
    htrans_e                trans;

    assign trans      = htrans_e'(bus.htrans_i);
    assign owner_lock = bus.hlock_i[grant_idx];

    // Value the burst counter takes at this edge; also feeds the arbitration decision.
    always_comb begin
        cnt_nxt = cnt;
        if (bus.hready_i) begin
            case (trans)
                TR_NONSEQ: cnt_nxt = beats_after_first(bus.hburst_i);
                TR_SEQ:    cnt_nxt = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
                TR_IDLE:   cnt_nxt = 4'd0;
                default:   cnt_nxt = cnt;    // BUSY holds
            endcase
        end
    end

    // Re-arbitrate once the penultimate address is accepted, so the last beat
    // is still issued by the current owner while the new grant is already visible.
    assign arb_ok = bus.hready_i & ~owner_lock & (cnt_nxt <= 4'd1);

    // Round-robin: rotate a doubled request vector so bit j means master
    // (grant_idx + 1 + j) mod NUM_MST; the current owner lands in the last slot.
    assign req_dbl  = {bus.hbusreq_i, bus.hbusreq_i};
    assign grant_p1 = {1'b0, grant_idx} + ONE_W;
    assign req_rot  = req_dbl >> grant_p1;

    always_comb begin
        winner = DEF_IDX;
        cand   = '0;
        if (|bus.hbusreq_i) begin
            if (ARB_MODE == 0) begin
                // Descending scan: the last hit is the lowest set index.
                for (int j = NUM_MST - 1; j >= 0; j--) begin
                    if (bus.hbusreq_i[j]) begin
                        winner = MW'(j);
                    end
                end
            end else begin
                for (int j = NUM_MST - 1; j >= 0; j--) begin
                    cand = grant_p1 + (MW+1)'(j);
                    if (cand >= NUM_W) begin
                        cand = cand - NUM_W;
                    end
                    if (req_rot[j]) begin
                        winner = cand[MW-1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_idx      <= DEF_IDX;
            hmaster_q      <= DEF_IDX;
            hmaster_data_q <= DEF_IDX;
            hmastlock_q    <= 1'b0;
            cnt            <= 4'd0;
        end else if (bus.hready_i) begin
            cnt            <= cnt_nxt;
            // Ownership follows the grant held before this edge; data phase trails one more.
            hmaster_q      <= grant_idx;
            hmastlock_q    <= owner_lock;
            hmaster_data_q <= hmaster_q;
            if (arb_ok) begin
                grant_idx <= winner;
            end
        end
    end

    // Decoding a single index keeps the grant one-hot by construction.
    always_comb begin
        grant_vec            = '0;
        grant_vec[grant_idx] = 1'b1;
    end

    assign bus.hgrant_o       = grant_vec;
    assign bus.hmaster_o      = hmaster_q;
    assign bus.hmaster_data_o = hmaster_data_q;
    assign bus.hmastlock_o    = hmastlock_q;
endmodule

// File: tb/tb_ahb2_arbiter_nm.sv
// Purpose: bench for ahb2_arbiter_nm; a fixed-priority and a round-robin instance share all stimulus.
// Latency: each step drives inputs 1ns after an edge and samples 1ns after the next edge.
// Backpressure: hready is driven directly, including multi-cycle stalls.
module tb_ahb2_arbiter_nm;
    localparam int N   = 4;
    localparam int DEF = 0;
    localparam int BEATS_LEFT [8] = '{0, 0, 3, 3, 7, 7, 15, 15};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] lock = '0;
    logic [1:0] trans = '0;
    logic [2:0] burst = '0;
    logic       ready = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state, index 0 = fixed priority instance, 1 = round robin instance.
    int m_grant [2];
    int m_owner [2];
    int m_data  [2];
    int m_lock  [2];
    int m_cnt   [2];

    always #5 clk = ~clk;

    ahb2_arbiter_nm_if #(.NUM_MST(N)) bus_fp ();
    ahb2_arbiter_nm_if #(.NUM_MST(N)) bus_rr ();

    assign bus_fp.hbusreq_i = req;
    assign bus_fp.hlock_i   = lock;
    assign bus_fp.htrans_i  = trans;
    assign bus_fp.hburst_i  = burst;
    assign bus_fp.hready_i  = ready;
    assign bus_rr.hbusreq_i = req;
    assign bus_rr.hlock_i   = lock;
    assign bus_rr.htrans_i  = trans;
    assign bus_rr.hburst_i  = burst;
    assign bus_rr.hready_i  = ready;

    ahb2_arbiter_nm #(.NUM_MST(N), .DEFAULT_MST(DEF), .ARB_MODE(0)) u_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_fp)
    );

    ahb2_arbiter_nm #(.NUM_MST(N), .DEFAULT_MST(DEF), .ARB_MODE(1)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_rr)
    );

    function automatic bit bit_of(logic [3:0] v, int i);
        return ((v >> i) & 4'd1) != 4'd0;
    endfunction

    // Winner per the arbitration rules, written as a plain scan.
    function automatic int pick(int mode, int cur, logic [3:0] r);
        if (r == 4'd0) return DEF;
        if (mode == 0) begin
            for (int i = 0; i < N; i++) if (bit_of(r, i)) return i;
        end else begin
            for (int k = 1; k <= N; k++) if (bit_of(r, (cur + k) % N)) return (cur + k) % N;
        end
        return DEF;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_grant[m] = DEF; m_owner[m] = DEF; m_data[m] = DEF; m_lock[m] = 0; m_cnt[m] = 0;
        end
    endtask

    // Effect of one rising edge with the inputs currently applied.
    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            if (ready) begin
                int nc;
                int ng;
                int lk;
                nc = m_cnt[m];
                case (trans)
                    2'd2: nc = BEATS_LEFT[burst];
                    2'd3: nc = (m_cnt[m] > 0) ? m_cnt[m] - 1 : 0;
                    2'd0: nc = 0;
                    default: nc = m_cnt[m];
                endcase
                lk = bit_of(lock, m_grant[m]) ? 1 : 0;
                ng = (lk == 0 && nc <= 1) ? pick(m, m_grant[m], req) : m_grant[m];
                m_data[m]  = m_owner[m];
                m_owner[m] = m_grant[m];
                m_lock[m]  = lk;
                m_cnt[m]   = nc;
                m_grant[m] = ng;
            end
        end
    endtask

    function automatic logic [31:0] obs(int m, int w);
        logic [31:0] r;
        r = '0;
        case (w)
            0: r = (m == 0) ? 32'(bus_fp.hgrant_o)       : 32'(bus_rr.hgrant_o);
            1: r = (m == 0) ? 32'(bus_fp.hmaster_o)      : 32'(bus_rr.hmaster_o);
            2: r = (m == 0) ? 32'(bus_fp.hmaster_data_o) : 32'(bus_rr.hmaster_data_o);
            3: r = (m == 0) ? 32'(bus_fp.hmastlock_o)    : 32'(bus_rr.hmastlock_o);
            default: r = (m == 0) ? 32'(u_fp.cnt)        : 32'(u_rr.cnt);
        endcase
        return r;
    endfunction

    function automatic logic [31:0] model_val(int m, int w);
        logic [31:0] r;
        case (w)
            0: r = 32'(1) << m_grant[m];
            1: r = 32'(m_owner[m]);
            2: r = 32'(m_data[m]);
            3: r = 32'(m_lock[m]);
            default: r = 32'(m_cnt[m]);
        endcase
        return r;
    endfunction

    function automatic string wname(int w);
        case (w)
            0: return "hgrant";
            1: return "hmaster";
            2: return "hmaster_data";
            3: return "hmastlock";
            default: return "cnt";
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] observed, logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Compare every output of both instances against the reference model.
    task automatic check_all(string tag);
        for (int m = 0; m < 2; m++)
            for (int w = 0; w < 5; w++)
                chk($sformatf("%s.%s.%s", tag, (m == 0) ? "fp" : "rr", wname(w)), obs(m, w), model_val(m, w));
    endtask

    // Compare one output of both instances against a directed constant.
    task automatic chk2(string tag, int w, logic [31:0] expected);
        for (int m = 0; m < 2; m++)
            chk($sformatf("%s.%s.%s", tag, (m == 0) ? "fp" : "rr", wname(w)), obs(m, w), expected);
    endtask

    task automatic step(string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Reset lands mid-cycle so its effect is checked without any clock edge.
    task automatic do_reset(string tag);
        #2;
        rst_n = 1'b0;
        req = '0; lock = '0; trans = 2'd0; burst = 3'd0; ready = 1'b1;
        model_reset();
        #1;
        chk2({tag, ".async"}, 0, 32'(1) << DEF);
        chk2({tag, ".async"}, 4, 32'd0);
        check_all(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int seq [5];
        seq = '{1, 2, 3, 0, 1};

        // 1: idle bus parks on the default master
        @(posedge clk);
        #1;
        do_reset("t1.rst");
        for (int i = 0; i < 10; i++) begin
            step("t1");
            chk2("t1.idle", 0, 32'h1);
            chk2("t1.idle", 1, 32'h0);
            chk2("t1.idle", 3, 32'h0);
        end

        // 2: grant, then ownership, then data phase, one edge apart
        do_reset("t2.rst");
        req = 4'b1010;
        step("t2");
        chk2("t2.edge1", 0, 32'b0010);
        step("t2");
        chk2("t2.edge2", 1, 32'd1);
        step("t2");
        chk2("t2.edge3", 2, 32'd1);

        // 3: round robin rotation on single transfers
        do_reset("t3.rst");
        req = 4'b1111; trans = 2'd2; burst = 3'd0;
        for (int i = 0; i < 5; i++) begin
            step("t3");
            chk($sformatf("t3.rr.seq%0d", i), 32'(bus_rr.hgrant_o), 32'(1) << seq[i]);
            chk($sformatf("t3.fp.seq%0d", i), 32'(bus_fp.hgrant_o), 32'h1);
        end

        // 4 and 5: INCR4 by M1, M2 waiting, without and with a 5-cycle stall
        for (int pass = 0; pass < 2; pass++) begin
            do_reset("t4.rst");
            req = 4'b0010; trans = 2'd0;
            step("t4.idle");
            step("t4.idle");
            req = 4'b0100; trans = 2'd2; burst = 3'd3;
            step("t4.b1");
            chk2("t4.b1", 0, 32'b0010);
            trans = 2'd3;
            step("t4.b2");
            chk2("t4.b2", 4, 32'd2);
            if (pass == 1) begin
                ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step("t5.stall");
                    chk2("t5.stall", 0, 32'b0010);
                    chk2("t5.stall", 1, 32'd1);
                    chk2("t5.stall", 2, 32'd1);
                    chk2("t5.stall", 4, 32'd2);
                end
                ready = 1'b1;
            end
            step("t4.b3");
            chk2("t4.b3", 0, 32'b0100);
            chk2("t4.b3", 1, 32'd1);
            step("t4.b4");
            chk2("t4.b4", 1, 32'd2);
            chk2("t4.b4", 4, 32'd0);
        end

        // 6: locked sequence by M2 with M0 requesting
        do_reset("t6.rst");
        req = 4'b0100; lock = 4'b0100; trans = 2'd0;
        step("t6.req");
        step("t6.own");
        req = 4'b0101; trans = 2'd2; burst = 3'd0;
        for (int i = 0; i < 3; i++) begin
            step("t6.lock");
            chk2("t6.lock", 0, 32'b0100);
            chk2("t6.lock", 3, 32'd1);
        end
        lock = 4'b0000;
        step("t6.unlock");
        chk2("t6.unlock", 0, 32'b0001);

        // Reset in the middle of an INCR8
        do_reset("t7.rst");
        req = 4'b0010; trans = 2'd0;
        step("t7.idle");
        step("t7.idle");
        trans = 2'd2; burst = 3'd5;
        step("t7.b1");
        trans = 2'd3;
        step("t7.b2");
        chk2("t7.b2", 4, 32'd6);
        do_reset("t7.midburst");

        // Random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            req   = 4'($urandom);
            lock  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
            trans = 2'($urandom_range(0, 3));
            burst = 3'($urandom_range(0, 7));
            ready = ($urandom_range(0, 3) != 0);
            step("rnd");
            chk("rnd.fp.onehot", 32'($onehot(bus_fp.hgrant_o)), 32'd1);
            chk("rnd.rr.onehot", 32'($onehot(bus_rr.hgrant_o)), 32'd1);
            if (i == 300) do_reset("rnd.rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
